radix_4_ntt_ctrl: RTL and testbench

//  Sequencer for an in-place radix-4 DIT NTT of LEN = 4**STAGES points.

---
 rtl/radix_4_ntt_ctrl.sv | 162 ++++++++++++++++
 tb/tb_radix_4_ntt_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/radix_4_ntt_ctrl.sv
// Sequencer for an in-place radix-4 DIT NTT of 4**STAGES points: one butterfly
// issued per cycle, matching write-back strobes and addresses LAT cycles later.
module radix_4_ntt_ctrl #(
   parameter int STAGES = 3,
   parameter int AW     = 6,
   parameter int SW     = 2,
   parameter int LAT    = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          inverse,
   output logic          busy,
   output logic          done,
   output logic [SW-1:0] stage,
   output logic          rd_en,
   output logic [AW-1:0] rd_addr0,
   output logic [AW-1:0] rd_addr1,
   output logic [AW-1:0] rd_addr2,
   output logic [AW-1:0] rd_addr3,
   output logic [AW-1:0] tw_exp,
   output logic          tw_inv,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr0,
   output logic [AW-1:0] wr_addr1,
   output logic [AW-1:0] wr_addr2,
   output logic [AW-1:0] wr_addr3
);

   localparam int KW = AW - 2;                      // LEN/4 butterflies per stage
   localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
   typedef logic [3:0][AW-1:0] quad_t;
   typedef struct packed {
      logic  en;
      quad_t addr;
   } wb_t;

   state_t          state_q;
   logic [KW-1:0]   k_q;
   logic [SW-1:0]   stage_q;
   logic [CW-1:0]   drain_q;
   logic            busy_q, done_q, rd_en_q, tw_inv_q;
   quad_t           rd_addr_q;
   logic [AW-1:0]   tw_exp_q;
   wb_t             pipe_q [LAT];

   // Address of the butterfly that the next edge will issue.
   logic [KW-1:0]   issue_k_d;
   logic [SW-1:0]   issue_s_d;
   logic [SW:0]     sh_d;
   logic [AW-1:0]   k_ext_d, mask_d, j_d, base_d, tw_exp_d;
   quad_t           rd_addr_d;

   always_comb begin
      // NOTE: every signal gets a default before any branch so no latch is inferred.
      issue_k_d = k_q + KW'(1);
      issue_s_d = stage_q;
      if (state_q == IDLE) begin
         issue_k_d = '0;
         issue_s_d = '0;
      end else if (state_q == DRAIN) begin
         issue_k_d = '0;
         issue_s_d = stage_q + SW'(1);
      end
      // span = 4**s: j is k mod span, and k/span*4*span is (k with j cleared) << 2.
      sh_d     = {issue_s_d, 1'b0};
      k_ext_d  = AW'(issue_k_d);
      mask_d   = (AW'(1) << sh_d) - AW'(1);
      j_d      = k_ext_d & mask_d;
      base_d   = ((k_ext_d & ~mask_d) << 2) | j_d;
      for (int i = 0; i < 4; i++) rd_addr_d[i] = base_d | (AW'(i) << sh_d);
      tw_exp_d = j_d << {SW'(STAGES - 1) - issue_s_d, 1'b0};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         k_q       <= '0;
         stage_q   <= '0;
         drain_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rd_en_q   <= 1'b0;
         tw_inv_q  <= 1'b0;
         rd_addr_q <= '0;
         tw_exp_q  <= '0;
         // NOTE: the delay line is cleared too, so butterflies issued before a
         // reset can never produce a late write strobe.
         for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
      end else begin
         done_q    <= 1'b0;
         rd_en_q   <= 1'b0;
         pipe_q[0] <= {rd_en_q, rd_addr_q};
         for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];

         case (state_q)
            IDLE: if (start) begin
               state_q   <= ISSUE;
               tw_inv_q  <= inverse;
               stage_q   <= '0;
               k_q       <= '0;
               busy_q    <= 1'b1;
               rd_en_q   <= 1'b1;
               rd_addr_q <= rd_addr_d;
               tw_exp_q  <= tw_exp_d;
            end
            ISSUE: begin
               if (k_q == '1) begin
                  state_q <= DRAIN;
                  drain_q <= '0;
               end else begin
                  k_q       <= issue_k_d;
                  rd_en_q   <= 1'b1;
                  rd_addr_q <= rd_addr_d;
                  tw_exp_q  <= tw_exp_d;
               end
            end
            DRAIN: begin
               if (drain_q == CW'(LAT - 1)) begin
                  if (stage_q == SW'(STAGES - 1)) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q   <= ISSUE;
                     stage_q   <= issue_s_d;
                     k_q       <= '0;
                     rd_en_q   <= 1'b1;
                     rd_addr_q <= rd_addr_d;
                     tw_exp_q  <= tw_exp_d;
                  end
               end else begin
                  drain_q <= drain_q + CW'(1);
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign stage    = stage_q;
   assign rd_en    = rd_en_q;
   assign rd_addr0 = rd_addr_q[0];
   assign rd_addr1 = rd_addr_q[1];
   assign rd_addr2 = rd_addr_q[2];
   assign rd_addr3 = rd_addr_q[3];
   assign tw_exp   = tw_exp_q;
   assign tw_inv   = tw_inv_q;
   assign wr_en    = pipe_q[LAT-1].en;
   assign wr_addr0 = pipe_q[LAT-1].addr[0];
   assign wr_addr1 = pipe_q[LAT-1].addr[1];
   assign wr_addr2 = pipe_q[LAT-1].addr[2];
   assign wr_addr3 = pipe_q[LAT-1].addr[3];

endmodule

// File: tb/tb_radix_4_ntt_ctrl.sv
// Directed bench for radix_4_ntt_ctrl (STAGES=3, LAT=2): captures each cycle of
// a transform and compares against hand values and an arithmetic schedule model.
module tb_radix_4_ntt_ctrl;

   logic       clk = 1'b0;
   logic       rst_n, start, inverse;
   logic       busy, done, rd_en, tw_inv, wr_en;
   logic [1:0] stage;
   logic [5:0] rd_addr0, rd_addr1, rd_addr2, rd_addr3, tw_exp;
   logic [5:0] wr_addr0, wr_addr1, wr_addr2, wr_addr3;

   always #5 clk = ~clk;

   radix_4_ntt_ctrl #(.STAGES(3), .AW(6), .SW(2), .LAT(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .inverse(inverse),
      .busy(busy), .done(done), .stage(stage), .rd_en(rd_en),
      .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_addr3(rd_addr3),
      .tw_exp(tw_exp), .tw_inv(tw_inv), .wr_en(wr_en),
      .wr_addr0(wr_addr0), .wr_addr1(wr_addr1), .wr_addr2(wr_addr2), .wr_addr3(wr_addr3)
   );

   typedef struct packed {
      logic        rd_en, wr_en, busy, done, tw_inv;
      logic [1:0]  stage;
      logic [23:0] rd, wr;
      logic [5:0]  e;
   } obs_t;

   obs_t  obs [64];
   int    cyc;
   int    passed = 0;
   int    total  = 0;
   logic [60:0] all_out;

   assign all_out = {busy, done, stage, rd_en, rd_addr0, rd_addr1, rd_addr2, rd_addr3,
                     tw_exp, tw_inv, wr_en, wr_addr0, wr_addr1, wr_addr2, wr_addr3};

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (cyc >= 0 && cyc < 64)
         obs[cyc] = '{rd_en: rd_en, wr_en: wr_en, busy: busy, done: done, tw_inv: tw_inv,
                      stage: stage, rd: {rd_addr3, rd_addr2, rd_addr1, rd_addr0},
                      wr: {wr_addr3, wr_addr2, wr_addr1, wr_addr0}, e: tw_exp};
   endtask

   // Start sampled at the edge ending cycle 0; obs[c] holds cycle c.
   task automatic run_capture(input logic inv, input bit pulse_mid, input int last);
      inverse = inv;
      start   = 1'b1;
      cyc     = 0;
      step();
      start = 1'b0;
      while (cyc < last) begin
         start = pulse_mid && (cyc == 10 || cyc == 40);
         if (pulse_mid && cyc == 5) inverse = ~inv;
         step();
      end
      start = 1'b0;
   endtask

   // Schedule model: 18-cycle stage slots (16 issue + 2 drain) starting at cycle 1.
   function automatic bit exp_rd_en(input int c);
      return c >= 1 && (c - 1) / 18 < 3 && (c - 1) % 18 < 16;
   endfunction

   function automatic logic [23:0] exp_addrs(input int c);
      int s, k, span, j, g, base;
      logic [23:0] r;
      s = (c - 1) / 18; k = (c - 1) % 18;
      span = 4 ** s; j = k % span; g = k / span;
      base = g * 4 * span + j;
      for (int i = 0; i < 4; i++) r[i*6 +: 6] = 6'(base + i * span);
      return r;
   endfunction

   function automatic logic [5:0] exp_e(input int c);
      int s, k, j;
      s = (c - 1) / 18; k = (c - 1) % 18;
      j = k % (4 ** s);
      return 6'((j * (4 ** (2 - s))) % 64);
   endfunction

   task automatic check_schedule(input string tag, input logic inv);
      int last_c = 0;
      for (int c = 1; c <= 56; c++) begin
         total++;
         if (obs[c].rd_en !== exp_rd_en(c))
            $display("FAIL %s rd_en c%0d got %b exp %b", tag, c, obs[c].rd_en, exp_rd_en(c));
         else passed++;
         if (exp_rd_en(c)) begin
            last_c = c;
            total++;
            if ({obs[c].rd, obs[c].e} !== {exp_addrs(c), exp_e(c)})
               $display("FAIL %s rd_addr c%0d got %h/%0d exp %h/%0d", tag, c,
                        obs[c].rd, obs[c].e, exp_addrs(c), exp_e(c));
            else passed++;
         end else if (last_c != 0) begin
            total++;
            if (obs[c].rd !== exp_addrs(last_c))
               $display("FAIL %s rd_hold c%0d got %h exp %h", tag, c, obs[c].rd, exp_addrs(last_c));
            else passed++;
         end
         total++;
         if (obs[c].wr_en !== (c >= 3 && exp_rd_en(c - 2)))
            $display("FAIL %s wr_en c%0d got %b", tag, c, obs[c].wr_en);
         else passed++;
         if (c >= 3 && exp_rd_en(c - 2)) begin
            total++;
            if (obs[c].wr !== exp_addrs(c - 2))
               $display("FAIL %s wr_addr c%0d got %h exp %h", tag, c, obs[c].wr, exp_addrs(c - 2));
            else passed++;
         end
         total++;
         if ({obs[c].busy, obs[c].done} !== {c <= 55, c == 55})
            $display("FAIL %s busy_done c%0d got %b%b", tag, c, obs[c].busy, obs[c].done);
         else passed++;
         if (c <= 55) begin
            total++;
            if ({obs[c].stage, obs[c].tw_inv} !== {2'((c == 55) ? 2 : (c - 1) / 18), inv})
               $display("FAIL %s stage_inv c%0d got %0d/%b", tag, c, obs[c].stage, obs[c].tw_inv);
            else passed++;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; inverse = 1'b0;
      repeat (5) begin
         step();
         total++;
         if (all_out !== '0) $display("FAIL reset_outputs got %h exp 0", all_out);
         else passed++;
      end
      rst_n = 1'b1;
      repeat (6) begin
         step();
         total++;
         if ({rd_en, wr_en, busy, done} !== 4'b0000)
            $display("FAIL idle_quiet got %b exp 0000", {rd_en, wr_en, busy, done});
         else passed++;
      end
   endtask

   task automatic test_stage0();
      run_capture(1'b0, 1'b0, 57);
      total++;
      if ({obs[1].rd, obs[1].e} !== {6'd3, 6'd2, 6'd1, 6'd0, 6'd0})
         $display("FAIL stage0_c1 got %h/%0d exp 03020100/0", obs[1].rd, obs[1].e);
      else passed++;
      total++;
      if ({obs[2].rd, obs[2].e} !== {6'd7, 6'd6, 6'd5, 6'd4, 6'd0})
         $display("FAIL stage0_c2 got %h/%0d exp 4..7/0", obs[2].rd, obs[2].e);
      else passed++;
      for (int c = 1; c <= 18; c++) begin
         total++;
         if (obs[c].rd_en !== (c <= 16))
            $display("FAIL stage0_rd_en c%0d got %b exp %b", c, obs[c].rd_en, c <= 16);
         else passed++;
      end
   endtask

   task automatic test_stage1();
      total++;
      if ({obs[19].rd, obs[19].e, obs[19].stage} !== {6'd12, 6'd8, 6'd4, 6'd0, 6'd0, 2'd1})
         $display("FAIL stage1_k0 got %h/%0d/%0d exp 0,4,8,12/0/1", obs[19].rd, obs[19].e, obs[19].stage);
      else passed++;
      total++;
      if ({obs[20].rd, obs[20].e} !== {6'd13, 6'd9, 6'd5, 6'd1, 6'd4})
         $display("FAIL stage1_k1 got %h/%0d exp 1,5,9,13/4", obs[20].rd, obs[20].e);
      else passed++;
      total++;
      if ({obs[23].rd, obs[23].e} !== {6'd28, 6'd24, 6'd20, 6'd16, 6'd0})
         $display("FAIL stage1_k4 got %h/%0d exp 16,20,24,28/0", obs[23].rd, obs[23].e);
      else passed++;
   endtask

   task automatic test_stage2();
      total++;
      if ({obs[38].rd, obs[38].e, obs[38].stage} !== {6'd49, 6'd33, 6'd17, 6'd1, 6'd1, 2'd2})
         $display("FAIL stage2_k1 got %h/%0d/%0d exp 1,17,33,49/1/2", obs[38].rd, obs[38].e, obs[38].stage);
      else passed++;
      total++;
      if ({obs[52].rd, obs[52].e} !== {6'd63, 6'd47, 6'd31, 6'd15, 6'd15})
         $display("FAIL stage2_k15 got %h/%0d exp 15,31,47,63/15", obs[52].rd, obs[52].e);
      else passed++;
      for (int c = 1; c <= 57; c++) begin
         total++;
         if (obs[c].done !== (c == 55)) $display("FAIL done_pulse c%0d got %b", c, obs[c].done);
         else passed++;
      end
      total++;
      if ({obs[55].busy, obs[56].busy} !== 2'b10)
         $display("FAIL busy_fall got %b%b exp 10", obs[55].busy, obs[56].busy);
      else passed++;
   endtask

   task automatic test_inverse_and_mid_start();
      run_capture(1'b1, 1'b1, 57);
      check_schedule("inv_mid_start", 1'b1);
   endtask

   task automatic test_reset_mid();
      run_capture(1'b0, 1'b0, 25);
      rst_n = 1'b0;
      step();
      total++;
      if (all_out !== '0) $display("FAIL reset_mid_outputs got %h exp 0", all_out);
      else passed++;
      rst_n = 1'b1;
      repeat (20) begin
         step();
         total++;
         if ({rd_en, wr_en, busy} !== 3'b000)
            $display("FAIL after_reset_quiet got %b exp 000", {rd_en, wr_en, busy});
         else passed++;
      end
   endtask

   task automatic test_restart();
      run_capture(1'b0, 1'b0, 57);
      check_schedule("restart", 1'b0);
   endtask

   initial begin
      test_reset();
      test_stage0();
      test_stage1();
      test_stage2();
      check_schedule("schedule", 1'b0);
      test_inverse_and_mid_start();
      test_reset_mid();
      test_restart();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
